vdff_fifo: RTL and testbench

Parameterized synchronous FIFO that sits directly upstream of the `vdff` delayed-register stage. It absorbs bursty stimulus words from a testbench or producer and presents them, in order, one word per accepted transfer, on a `size`-bit bus that is wired straight into a `vdff` instance's `in` port. Both sides use a valid/ready handshake. The `size` parameter is listed first so that ordered-list overrides line up with `vdff`, e.g. `#(10,8)`.

---
 rtl/vdff_fifo_pkg.sv | 21 ++
 rtl/vdff_fifo_mem.sv | 27 ++
 rtl/vdff_fifo.sv | 64 ++++++
 tb/tb_vdff_fifo.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/vdff_fifo_pkg.sv
// Shared constants and helpers for the vdff FIFO stage.
// The default data width matches the downstream vdff register stage.
package vdff_fifo_pkg;

  localparam int unsigned DefaultSize  = 5;
  localparam int unsigned DefaultDepth = 4;

  // Constant ceiling-log2, used to size pointers and the occupancy counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/vdff_fifo_mem.sv
// depth x size register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module vdff_fifo_mem
  import vdff_fifo_pkg::*;
#(
  parameter int unsigned size  = DefaultSize,
  parameter int unsigned depth = DefaultDepth
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [clog2(depth)-1:0]   waddr,
  input  logic [size-1:0]           wdata,
  input  logic [clog2(depth)-1:0]   raddr,
  output logic [size-1:0]           rdata
);

  logic [size-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/vdff_fifo.sv
// First-word-fall-through synchronous FIFO feeding a vdff stage, valid/ready on both sides.
// Flags are decoded from the registered occupancy only; no path from in to out.
module vdff_fifo
  import vdff_fifo_pkg::*;
#(
  parameter int unsigned size  = DefaultSize,
  parameter int unsigned depth = DefaultDepth
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [size-1:0]         in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [size-1:0]         out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [clog2(depth):0]   level
);

  localparam int unsigned Aw = clog2(depth);
  localparam int unsigned Lw = Aw + 1;

  logic [Aw-1:0]   wp_q, rp_q;
  logic [Lw-1:0]   level_q;
  logic [size-1:0] rdata;
  logic            wr, rd;

  // Full FIFO refuses a write even when it is being read the same cycle.
  assign in_ready  = !rst && (level_q != Lw'(depth));
  assign out_valid = (level_q != '0);
  assign wr        = in_valid && in_ready;
  assign rd        = out_valid && out_ready;
  assign out       = out_valid ? rdata : '0;
  assign level     = level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      level_q <= '0;
    end else begin
      if (wr) wp_q <= wp_q + 1'b1;
      if (rd) rp_q <= rp_q + 1'b1;
      case ({wr, rd})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  vdff_fifo_mem #(
    .size  (size),
    .depth (depth)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wp_q),
    .wdata (in),
    .raddr (rp_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_vdff_fifo.sv
// Randomized and directed bench for vdff_fifo against a queue-based reference model.
module tb_vdff_fifo;

  localparam int unsigned Size  = 5;
  localparam int unsigned Depth = 4;

  logic            clk;
  logic            rst;
  logic [Size-1:0] d_in;
  logic            in_valid;
  logic            in_ready;
  logic [Size-1:0] d_out;
  logic            out_valid;
  logic            out_ready;
  logic [2:0]      level;

  int total = 0;
  int bad   = 0;

  logic [Size-1:0] model_q[$];
  logic [Size-1:0] outs[$];

  vdff_fifo #(
    .size  (Size),
    .depth (Depth)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (d_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out       (d_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: drive, compare against the model, advance the model at the edge.
  task automatic step(input logic r, input logic iv, input logic [Size-1:0] d, input logic ordy,
                      output logic acc);
    logic exp_ir, exp_ov, rd;
    logic [Size-1:0] exp_out;
    rst = r; in_valid = iv; d_in = d; out_ready = ordy;
    #1;
    exp_ir  = !r && (model_q.size() != Depth);
    exp_ov  = (model_q.size() != 0);
    exp_out = exp_ov ? model_q[0] : '0;
    check_eq("in_ready", 32'(in_ready), 32'(exp_ir));
    check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
    check_eq("out", 32'(d_out), 32'(exp_out));
    check_eq("level", 32'(level), model_q.size());
    acc = iv && exp_ir;
    rd  = exp_ov && ordy && !r;
    if (out_valid && ordy && !r) outs.push_back(d_out);
    @(posedge clk);
    if (r) begin
      model_q.delete();
    end else begin
      if (rd) void'(model_q.pop_front());
      if (acc) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    logic iv;
    int nxt;
    int guard;
    rst = 1'b1; in_valid = 1'b0; d_in = '0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);

    // Reset held with in_valid asserted: nothing may be written.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5'h0A, 1'b0, acc);
    check_eq("rst_no_write", 32'(level), 0);

    // Fill to full, then a fifth word is held.
    for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 5'(i), 1'b0, acc);
    step(1'b0, 1'b1, 5'd5, 1'b0, acc);
    check_eq("full_reject", 32'(acc), 0);
    check_eq("full_level", 32'(level), 4);
    outs.delete();
    iv = 1'b1;
    guard = 0;
    while (model_q.size() != 0 || iv) begin
      step(1'b0, iv, 5'd5, 1'b1, acc);
      if (acc) iv = 1'b0;
      guard++;
      if (guard > 20) break;
    end
    check_eq("drain_count", outs.size(), 5);
    for (int i = 0; i < 5 && i < outs.size(); i++) check_eq("drain_order", 32'(outs[i]), i + 1);
    check_eq("drain_level", 32'(level), 0);

    // Simultaneous read and write at level 2.
    step(1'b0, 1'b1, 5'h11, 1'b0, acc);
    step(1'b0, 1'b1, 5'h12, 1'b0, acc);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 5'(5'h13 + i), 1'b1, acc);
    check_eq("mid_level", 32'(level), 2);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, acc);

    // Pointer wrap: 20 words with random ready and a holding producer.
    outs.delete();
    nxt = 0; iv = 1'b0; guard = 0;
    while (outs.size() < 20 && guard < 500) begin
      if (!iv && nxt < 20) iv = ($urandom_range(0, 3) != 0);
      step(1'b0, iv, 5'(nxt), 1'($urandom_range(0, 1)), acc);
      if (acc) begin nxt++; iv = 1'b0; end
      guard++;
    end
    check_eq("wrap_count", outs.size(), 20);
    for (int i = 0; i < 20 && i < outs.size(); i++) check_eq("wrap_order", 32'(outs[i]), i);

    // Empty bypass.
    step(1'b0, 1'b1, 5'h1F, 1'b1, acc);
    check_eq("bypass_acc", 32'(acc), 1);
    step(1'b0, 1'b0, '0, 1'b1, acc);
    step(1'b0, 1'b0, '0, 1'b0, acc);
    check_eq("bypass_gone", 32'(out_valid), 0);

    // Reset with three queued words.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 5'(5'h18 + i), 1'b0, acc);
    check_eq("pre_rst_level", 32'(level), 3);
    step(1'b1, 1'b0, '0, 1'b0, acc);
    outs.delete();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, 1'b1, acc);
    check_eq("rst_discard", outs.size(), 0);

    // Random soak.
    iv = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!iv) begin
        iv = ($urandom_range(0, 1) != 0);
        d_in = 5'($urandom);
      end
      step(($urandom_range(0, 63) == 0), iv, d_in, 1'($urandom_range(0, 1)), acc);
      if (acc || rst) iv = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
